ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) to the keyboard

---
 rtl/ps2_host_tx_pkg.sv | 27 ++
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_host_tx_line_filter.sv | 39 +++
 rtl/ps2_host_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmitter shared definitions.
// FSM encodings, command/reply bytes, frame builder.
package ps2_host_tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_BITS    = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam logic [7:0] CMD_LED     = 8'hED;
  localparam logic [7:0] CMD_SCAN_EN = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam logic [7:0] DEV_ACK    = 8'hFA;
  localparam logic [7:0] DEV_RESEND = 8'hFE;
  localparam logic [7:0] DEV_BAT_OK = 8'hAA;

  // Stop, odd parity, data; shifted out LSB first.
  function automatic logic [9:0] tx_frame(
    input logic [7:0] d
  );
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the
// PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       txreq;
  logic [7:0] txdata;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output txreq,
    output txdata,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  txreq,
    input  txdata,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// 8-sample deglitch of a PS/2 line plus a
// registered falling-edge pulse.
module ps2_host_tx_line_filter (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [7:0] shift_q;
  logic       level_q;
  logic       prev_q;
  logic       fall_q;

  // Level changes only after 8 agreeing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= 8'hFF;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else if (ce) begin
      shift_q <= {shift_q[6:0], line_i};
      if (shift_q == 8'hFF) begin
        level_q <= 1'b1;
      end else if (shift_q == 8'h00) begin
        level_q <= 1'b0;
      end
      prev_q <= level_q;
      fall_q <= prev_q & ~level_q;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Open-drain via ps2oe; bit 1 data, bit 0 clock.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_TICKS = 1750,
  parameter int TIMEOUT_TICKS = 28000,
  parameter int CNTW          = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic [1:0]   ps2,
  output logic [1:0]   ps2oe,
  ps2_host_tx_if.slave hif
);

  localparam logic [CNTW-1:0] INH_LAST =
    CNTW'(INHIBIT_TICKS - 1);
  localparam logic [CNTW-1:0] TMO_LAST =
    CNTW'(TIMEOUT_TICKS - 1);
  localparam logic [CNTW-1:0] TICK_ONE =
    CNTW'(1);

  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] tick_q, tick_d;
  logic [3:0]      bits_q, bits_d;
  logic [9:0]      sr_q, sr_d;
  logic [1:0]      oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            dat_s_q;
  logic            clk_f;
  logic            fall;
  logic            watch;

  ps2_host_tx_line_filter u_filt (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .line_i  (ps2[0]),
    .level_o (clk_f),
    .fall_o  (fall)
  );

  // Next-state: frame sequencing and the shared
  // inhibit/timeout tick counter.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bits_d  = bits_q;
    sr_d    = sr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    watch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        oe_d = 2'b00;
        if (hif.txreq) begin
          sr_d    = tx_frame(hif.txdata);
          tick_d  = '0;
          oe_d    = 2'b01;
          busy_d  = 1'b1;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        oe_d = 2'b01;
        if (tick_q == INH_LAST) begin
          oe_d    = 2'b11;
          state_d = ST_START;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      ST_START: begin
        oe_d    = 2'b10;
        tick_d  = '0;
        bits_d  = '0;
        state_d = ST_BITS;
      end
      ST_BITS: begin
        watch = 1'b1;
        if (fall) begin
          oe_d[1] = ~sr_q[0];
          sr_d    = {1'b0, sr_q[9:1]};
          bits_d  = bits_q + 4'd1;
          tick_d  = '0;
          if (bits_q == 4'd9) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        watch = 1'b1;
        if (fall) begin
          err_d   = dat_s_q;
          done_d  = 1'b1;
          oe_d    = 2'b00;
          tick_d  = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        oe_d = 2'b00;
        if (clk_f && dat_s_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          watch = 1'b1;
          if (fall) begin
            tick_d = '0;
          end
        end
      end
      default: begin
        oe_d    = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // A fall in the same ce always beats timeout.
    if (watch && !fall) begin
      if (tick_q == TMO_LAST) begin
        oe_d    = 2'b00;
        done_d  = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        tick_d = tick_q + TICK_ONE;
      end
    end
  end

  // State registers; reset releases both lines.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
      oe_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dat_s_q <= 1'b1;
    end else if (ce) begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bits_q  <= bits_d;
      sr_q    <= sr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dat_s_q <= ps2[1];
    end
  end

  assign ps2oe     = oe_q;
  assign hif.busy  = busy_q;
  assign hif.done  = done_q;
  assign hif.error = err_q;

endmodule
